// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the synchronous FIFO family.
package fifo_pkg;

  // Operating mode selected by the FWFT parameter.
  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Number of words addressed by an AW-bit pointer.
  function automatic int unsigned fifo_depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  // Width of the occupancy counter: must represent 0..DEPTH inclusive.
  // Users declare their counter type as
  //   typedef logic [fifo_cnt_w(AW)-1:0] fifo_cnt_t;
  // because a package cannot hold a type that depends on a module parameter.
  function automatic int unsigned fifo_cnt_w(input int unsigned aw);
    return aw + 1;
  endfunction

  // Map the integer FWFT parameter onto the mode enum.
  function automatic fifo_mode_e fifo_mode(input int unsigned fwft);
    return (fwft != 0) ? FIFO_FWFT : FIFO_STD;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// 1W1R storage array for the FIFO: synchronous read with read-enable, no reset.
// Kept behaviourally simple so it can be replaced by an SRAM macro.
module sync_fifo_ram
  import fifo_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned DEPTH = fifo_depth(AW);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; output holds when re is low.
  always_ff @(posedge clk) begin
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with optional first-word-fall-through, runtime
// almost-full/almost-empty thresholds, synchronous flush and sticky errors.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 8,
  parameter int unsigned FWFT = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wen,
  input  logic [DW-1:0] wdata,
  output logic          wfull,
  output logic          walmost_full,
  output logic          werr,
  input  logic          ren,
  output logic [DW-1:0] rdata,
  output logic          rempty,
  output logic          ralmost_empty,
  output logic          rerr,
  input  logic [AW:0]   af_thresh,
  input  logic [AW:0]   ae_thresh,
  output logic [AW:0]   data_cnt,
  output logic          ovf_sticky,
  output logic          udf_sticky,
  input  logic          err_clr
);

  localparam int unsigned DEPTH = fifo_depth(AW);
  localparam fifo_mode_e  MODE  = fifo_mode(FWFT);

  typedef logic [fifo_cnt_w(AW)-1:0] fifo_cnt_t;

  localparam fifo_cnt_t CNT_FULL = fifo_cnt_t'(DEPTH);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  fifo_cnt_t     cnt_q, cnt_d;
  logic          hv_q, hv_d;
  logic          zero_q, zero_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic          wa, ra;
  logic          ram_re;
  fifo_cnt_t     mem_cnt;
  logic [DW-1:0] ram_dout;

  sync_fifo_ram #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wa),
    .waddr (wptr_q),
    .wdata (wdata),
    .re    (ram_re),
    .raddr (rptr_q),
    .rdata (ram_dout)
  );

  // Status flags and handshake qualification; flush masks both requests.
  always_comb begin
    wfull         = (cnt_q == CNT_FULL);
    rempty        = (MODE == FIFO_FWFT) ? ~hv_q : (cnt_q == '0);
    walmost_full  = (cnt_q >= af_thresh);
    ralmost_empty = (cnt_q <= ae_thresh);
    wa            = wen & ~wfull  & ~flush;
    ra            = ren & ~rempty & ~flush;
    werr          = wen & wfull   & ~flush;
    rerr          = ren & rempty  & ~flush;
  end

  // Memory-side read scheduling: direct reads in standard mode, head prefetch in FWFT.
  always_comb begin
    // In FWFT the head word lives in the RAM output register and is counted
    // in cnt_q, so the array itself holds one word fewer while hv_q is set.
    mem_cnt = cnt_q - fifo_cnt_t'(hv_q);
    if (MODE == FIFO_FWFT) begin
      ram_re = ~flush & (mem_cnt != '0) & (~hv_q | ra);
    end else begin
      ram_re = ra;
    end
  end

  // Next-state for pointers, occupancy and head-valid.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    hv_d   = hv_q;
    zero_d = zero_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      hv_d   = 1'b0;
      zero_d = 1'b1;
    end else begin
      if (wa)     wptr_d = wptr_q + 1'b1;
      if (ram_re) rptr_d = rptr_q + 1'b1;
      unique case ({wa, ra})
        2'b10:   cnt_d = cnt_q + fifo_cnt_t'(1);
        2'b01:   cnt_d = cnt_q - fifo_cnt_t'(1);
        default: cnt_d = cnt_q;
      endcase
      if (MODE == FIFO_FWFT) begin
        if (ram_re)  hv_d = 1'b1;
        else if (ra) hv_d = 1'b0;
      end
      if (ram_re) zero_d = 1'b0;
    end
  end

  // Sticky error flags: a new error wins over a simultaneous clear.
  always_comb begin
    ovf_d = werr | (ovf_q & ~err_clr);
    udf_d = rerr | (udf_q & ~err_clr);
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      hv_q   <= 1'b0;
      zero_q <= 1'b1;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      hv_q   <= hv_d;
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  // The RAM output register cannot be reset, so a zero mask stands in for
  // a cleared rdata until the first read after reset or flush.
  assign rdata      = zero_q ? '0 : ram_dout;
  assign data_cnt   = cnt_q;
  assign ovf_sticky = ovf_q;
  assign udf_sticky = udf_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: standard AW=2, standard AW=3 and FWFT AW=3
// instances share one stimulus bus; each test checks the instance it targets.
module tb_sync_fifo_prog;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, flush, wen, ren, err_clr;
  logic [7:0] wdata;
  logic [2:0] af2, ae2;
  logic [3:0] af3, ae3;

  logic       s2_wfull, s2_waf, s2_werr, s2_rempty, s2_rae, s2_rerr, s2_ovf, s2_udf;
  logic [7:0] s2_rdata;
  logic [2:0] s2_cnt;
  logic       s3_wfull, s3_waf, s3_werr, s3_rempty, s3_rae, s3_rerr, s3_ovf, s3_udf;
  logic [7:0] s3_rdata;
  logic [3:0] s3_cnt;
  logic       f3_wfull, f3_waf, f3_werr, f3_rempty, f3_rae, f3_rerr, f3_ovf, f3_udf;
  logic [7:0] f3_rdata;
  logic [3:0] f3_cnt;

  sync_fifo_prog #(.DW(8), .AW(2), .FWFT(0)) u_s2 (
    .clk(clk), .rst(rst), .flush(flush), .wen(wen), .wdata(wdata),
    .wfull(s2_wfull), .walmost_full(s2_waf), .werr(s2_werr), .ren(ren),
    .rdata(s2_rdata), .rempty(s2_rempty), .ralmost_empty(s2_rae), .rerr(s2_rerr),
    .af_thresh(af2), .ae_thresh(ae2), .data_cnt(s2_cnt),
    .ovf_sticky(s2_ovf), .udf_sticky(s2_udf), .err_clr(err_clr)
  );

  sync_fifo_prog #(.DW(8), .AW(3), .FWFT(0)) u_s3 (
    .clk(clk), .rst(rst), .flush(flush), .wen(wen), .wdata(wdata),
    .wfull(s3_wfull), .walmost_full(s3_waf), .werr(s3_werr), .ren(ren),
    .rdata(s3_rdata), .rempty(s3_rempty), .ralmost_empty(s3_rae), .rerr(s3_rerr),
    .af_thresh(af3), .ae_thresh(ae3), .data_cnt(s3_cnt),
    .ovf_sticky(s3_ovf), .udf_sticky(s3_udf), .err_clr(err_clr)
  );

  sync_fifo_prog #(.DW(8), .AW(3), .FWFT(1)) u_f3 (
    .clk(clk), .rst(rst), .flush(flush), .wen(wen), .wdata(wdata),
    .wfull(f3_wfull), .walmost_full(f3_waf), .werr(f3_werr), .ren(ren),
    .rdata(f3_rdata), .rempty(f3_rempty), .ralmost_empty(f3_rae), .rerr(f3_rerr),
    .af_thresh(af3), .ae_thresh(ae3), .data_cnt(f3_cnt),
    .ovf_sticky(f3_ovf), .udf_sticky(f3_udf), .err_clr(err_clr)
  );

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else pass_cnt++;
  endtask

  task automatic drv(input logic fl, input logic we, input logic re, input logic ec,
                     input logic [7:0] wd);
    flush = fl; wen = we; ren = re; err_clr = ec; wdata = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       fl, we, re, ec;
    logic [7:0] wd;
    logic       x_werr, x_rerr;
    logic [2:0] x_cnt;
    logic       x_empty, x_full;
    logic [7:0] x_rdata;
    logic       x_ovf, x_udf;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];

  initial begin
    // fl we re ec wd  | werr rerr | cnt empty full rdata ovf udf
    tbl[0]  = '{0,1,0,0,8'd1,  0,0, 3'd1,0,0,8'd0, 0,0};
    tbl[1]  = '{0,1,0,0,8'd2,  0,0, 3'd2,0,0,8'd0, 0,0};
    tbl[2]  = '{0,1,0,0,8'd3,  0,0, 3'd3,0,0,8'd0, 0,0};
    tbl[3]  = '{0,1,0,0,8'd4,  0,0, 3'd4,0,1,8'd0, 0,0};
    tbl[4]  = '{0,1,0,0,8'd5,  1,0, 3'd4,0,1,8'd0, 1,0};
    tbl[5]  = '{0,0,1,0,8'd0,  0,0, 3'd3,0,0,8'd1, 1,0};
    tbl[6]  = '{0,0,1,0,8'd0,  0,0, 3'd2,0,0,8'd2, 1,0};
    tbl[7]  = '{0,0,1,0,8'd0,  0,0, 3'd1,0,0,8'd3, 1,0};
    tbl[8]  = '{0,0,1,0,8'd0,  0,0, 3'd0,1,0,8'd4, 1,0};
    tbl[9]  = '{0,0,1,0,8'd0,  0,1, 3'd0,1,0,8'd4, 1,1};
    tbl[10] = '{0,0,0,1,8'd0,  0,0, 3'd0,1,0,8'd4, 0,0};
    tbl[11] = '{0,1,1,0,8'd9,  0,1, 3'd1,0,0,8'd4, 0,1};
    tbl[12] = '{0,0,0,1,8'd0,  0,0, 3'd1,0,0,8'd4, 0,0};
    tbl[13] = '{0,0,1,0,8'd0,  0,0, 3'd0,1,0,8'd9, 0,0};
    tbl[14] = '{0,0,1,1,8'd0,  0,1, 3'd0,1,0,8'd9, 0,1};
    tbl[15] = '{0,0,0,1,8'd0,  0,0, 3'd0,1,0,8'd9, 0,0};
    tbl[16] = '{0,1,0,0,8'd10, 0,0, 3'd1,0,0,8'd9, 0,0};
    tbl[17] = '{0,1,0,0,8'd11, 0,0, 3'd2,0,0,8'd9, 0,0};
    tbl[18] = '{0,1,0,0,8'd12, 0,0, 3'd3,0,0,8'd9, 0,0};
    tbl[19] = '{0,1,0,0,8'd13, 0,0, 3'd4,0,1,8'd9, 0,0};
    tbl[20] = '{0,1,1,0,8'd14, 1,0, 3'd3,0,0,8'd10,1,0};
    tbl[21] = '{1,1,1,0,8'd15, 0,0, 3'd0,1,0,8'd0, 1,0};
    tbl[22] = '{0,0,0,1,8'd0,  0,0, 3'd0,1,0,8'd0, 0,0};

    af2 = 3'd3; ae2 = 3'd1;
    af3 = 4'd6; ae3 = 4'd1;
    rst = 1'b1;
    drv(0, 0, 0, 0, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state of every instance
    chk("rst s2 cnt", s2_cnt, 0);     chk("rst s2 empty", s2_rempty, 1);
    chk("rst s2 full", s2_wfull, 0);  chk("rst s2 rdata", s2_rdata, 0);
    chk("rst s2 ovf", s2_ovf, 0);     chk("rst s2 udf", s2_udf, 0);
    chk("rst s2 werr", s2_werr, 0);   chk("rst s2 rerr", s2_rerr, 0);
    chk("rst s2 af", s2_waf, 0);      chk("rst s2 ae", s2_rae, 1);
    chk("rst s3 cnt", s3_cnt, 0);     chk("rst s3 empty", s3_rempty, 1);
    chk("rst s3 full", s3_wfull, 0);  chk("rst s3 rdata", s3_rdata, 0);
    chk("rst s3 ovf", s3_ovf, 0);     chk("rst s3 udf", s3_udf, 0);
    chk("rst s3 werr", s3_werr, 0);   chk("rst s3 rerr", s3_rerr, 0);
    chk("rst s3 af", s3_waf, 0);      chk("rst s3 ae", s3_rae, 1);
    chk("rst f3 cnt", f3_cnt, 0);     chk("rst f3 empty", f3_rempty, 1);
    chk("rst f3 full", f3_wfull, 0);  chk("rst f3 rdata", f3_rdata, 0);
    chk("rst f3 ovf", f3_ovf, 0);     chk("rst f3 udf", f3_udf, 0);
    chk("rst f3 werr", f3_werr, 0);   chk("rst f3 rerr", f3_rerr, 0);
    chk("rst f3 af", f3_waf, 0);      chk("rst f3 ae", f3_rae, 1);

    // Table: standard mode AW=2 fill/overflow/drain/underflow/sticky/flush
    for (int i = 0; i < NV; i++) begin
      drv(tbl[i].fl, tbl[i].we, tbl[i].re, tbl[i].ec, tbl[i].wd);
      #1;
      chk($sformatf("tbl%0d werr", i), s2_werr, tbl[i].x_werr);
      chk($sformatf("tbl%0d rerr", i), s2_rerr, tbl[i].x_rerr);
      tick();
      chk($sformatf("tbl%0d cnt", i),   s2_cnt,    tbl[i].x_cnt);
      chk($sformatf("tbl%0d empty", i), s2_rempty, tbl[i].x_empty);
      chk($sformatf("tbl%0d full", i),  s2_wfull,  tbl[i].x_full);
      chk($sformatf("tbl%0d rdata", i), s2_rdata,  tbl[i].x_rdata);
      chk($sformatf("tbl%0d ovf", i),   s2_ovf,    tbl[i].x_ovf);
      chk($sformatf("tbl%0d udf", i),   s2_udf,    tbl[i].x_udf);
    end

    // FWFT single word: two-cycle write-to-visible latency, pop empties
    drv(1, 0, 0, 1, 8'd0); tick();
    drv(0, 1, 0, 0, 8'hA5); tick();
    chk("fw1 empty@E", f3_rempty, 1);
    chk("fw1 cnt@E", f3_cnt, 1);
    drv(0, 0, 0, 0, 8'd0); tick();
    chk("fw1 empty@E+1", f3_rempty, 0);
    chk("fw1 rdata@E+1", f3_rdata, 8'hA5);
    drv(0, 0, 1, 0, 8'd0);
    #1;
    chk("fw1 rerr", f3_rerr, 0);
    tick();
    chk("fw1 empty pop", f3_rempty, 1);
    chk("fw1 cnt pop", f3_cnt, 0);
    chk("fw1 rdata stale", f3_rdata, 8'hA5);

    // Streaming at constant occupancy 4 across pointer wrap, both modes
    drv(1, 0, 0, 1, 8'd0); tick();
    for (int k = 0; k < 4; k++) begin
      drv(0, 1, 0, 0, 8'(k)); tick();
    end
    drv(0, 0, 0, 0, 8'd0);
    chk("str f3 head", f3_rdata, 0);
    for (int k = 0; k < 20; k++) begin
      drv(0, 1, 1, 0, 8'(k + 4)); tick();
      chk($sformatf("str%0d s3 cnt", k), s3_cnt, 4);
      chk($sformatf("str%0d f3 cnt", k), f3_cnt, 4);
      chk($sformatf("str%0d s3 rdata", k), s3_rdata, 8'(k));
      chk($sformatf("str%0d f3 rdata", k), f3_rdata, 8'(k + 1));
      chk($sformatf("str%0d f3 empty", k), f3_rempty, 0);
    end

    // Thresholds af=6 ae=1 while filling past capacity, then flush at cnt 5
    drv(1, 0, 0, 1, 8'd0); tick();
    chk("thr0 s3 ae", s3_rae, 1);
    chk("thr0 s3 af", s3_waf, 0);
    for (int k = 1; k <= 9; k++) begin
      int unsigned c;
      c = (k > 8) ? 8 : k;
      drv(0, 1, 0, 0, 8'(k));
      #1;
      chk($sformatf("thr%0d s3 werr", k), s3_werr, (k == 9));
      chk($sformatf("thr%0d f3 werr", k), f3_werr, (k == 9));
      tick();
      chk($sformatf("thr%0d s3 cnt", k), s3_cnt, c);
      chk($sformatf("thr%0d f3 cnt", k), f3_cnt, c);
      chk($sformatf("thr%0d s3 af", k), s3_waf, (c >= 6));
      chk($sformatf("thr%0d f3 af", k), f3_waf, (c >= 6));
      chk($sformatf("thr%0d s3 ae", k), s3_rae, (c <= 1));
      chk($sformatf("thr%0d f3 ae", k), f3_rae, (c <= 1));
      chk($sformatf("thr%0d s3 full", k), s3_wfull, (c == 8));
      chk($sformatf("thr%0d f3 full", k), f3_wfull, (c == 8));
    end
    for (int k = 0; k < 3; k++) begin
      drv(0, 0, 1, 0, 8'd0); tick();
    end
    chk("fl s3 cnt5", s3_cnt, 5);
    chk("fl f3 cnt5", f3_cnt, 5);
    drv(1, 1, 0, 0, 8'd77);
    #1;
    chk("fl s3 werr", s3_werr, 0);
    chk("fl f3 werr", f3_werr, 0);
    tick();
    chk("fl s3 cnt", s3_cnt, 0);
    chk("fl f3 cnt", f3_cnt, 0);
    chk("fl s3 rdata", s3_rdata, 0);
    chk("fl f3 rdata", f3_rdata, 0);
    chk("fl f3 empty", f3_rempty, 1);
    chk("fl s3 ovf kept", s3_ovf, 1);
    chk("fl f3 ovf kept", f3_ovf, 1);
    drv(0, 0, 0, 1, 8'd0); tick();
    chk("clr f3 ovf", f3_ovf, 0);

    // Asynchronous reset mid-burst in FWFT mode
    drv(1, 0, 0, 1, 8'd0); tick();
    drv(0, 0, 1, 0, 8'd0); tick();
    chk("ar f3 udf set", f3_udf, 1);
    drv(0, 1, 0, 0, 8'h11); tick();
    drv(0, 1, 0, 0, 8'h22); tick();
    drv(0, 1, 0, 0, 8'h33); tick();
    drv(0, 0, 0, 0, 8'd0); tick();
    chk("ar f3 cnt3", f3_cnt, 3);
    chk("ar f3 head", f3_rdata, 8'h11);
    drv(0, 1, 0, 0, 8'h44);
    #2;
    rst = 1'b1;
    #1;
    chk("ar f3 cnt", f3_cnt, 0);
    chk("ar f3 empty", f3_rempty, 1);
    chk("ar f3 full", f3_wfull, 0);
    chk("ar f3 rdata", f3_rdata, 0);
    chk("ar f3 udf", f3_udf, 0);
    chk("ar f3 ovf", f3_ovf, 0);
    chk("ar f3 ae", f3_rae, 1);
    chk("ar f3 af", f3_waf, 0);
    drv(0, 0, 0, 0, 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drv(0, 1, 0, 0, 8'h3C); tick();
    drv(0, 0, 0, 0, 8'd0); tick();
    chk("ar post empty", f3_rempty, 0);
    chk("ar post rdata", f3_rdata, 8'h3C);
    chk("ar post cnt", f3_cnt, 1);
    drv(0, 0, 1, 0, 8'd0); tick();
    chk("ar post pop", f3_rempty, 1);
    drv(0, 0, 0, 0, 8'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
